prbs_gen_chk: RTL
=================

# prbs_gen_chk

Parametrised PRBS engine for the channel FPGA. It generates a pseudo-random word stream, or checks a received one, advancing a Fibonacci LFSR by W bits per clock. It supports the PRBS7, PRBS15, PRBS23 and PRBS31 polynomials, a self-synchronising checker with lock/loss hysteresis, and a saturating bit-error counter. It serves link and ADC-path test modes: the generator feeds the serial/data path, and the checker sits on the receive side.

## Interface

**Parameters**

- W, 12: word width, 1..64 bits per step.
- POLY, 23: polynomial select. 7 = x^7+x^6+1, 15 = x^15+x^14+1, 23 = x^23+x^18+1, 31 = x^31+x^28+1. Let L = POLY.
- LOCK_WORDS, 8: consecutive error-free words required to lock, 1..255.
- LOSS_WORDS, 4: consecutive erroneous words required to drop lock, 1..255.
- CNT_W, 32: error counter width.

**Ports**

- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- MODE  in  1  0 = generator, 1 = checker. Quasi-static.
- SEED  in  31  generator seed; low L bits used.
- LOAD  in  1  generator: load SEED on this cycle.
- GEN_EN  in  1  generator: advance and emit one word.
- DOUT  out  W  generated word.
- DOUT_VALID  out  1  DOUT updated this cycle.
- DIN  in  W  received word.
- DIN_VALID  in  1  DIN qualifies.
- LOCKED  out  1  checker locked.
- ERR_FLAG  out  1  one-cycle pulse when a word checked while locked has ≥1 bit error.
- ERR_CNT  out  CNT_W  saturating count of bit errors seen while locked.
- ERR_CLR  in  1  synchronous clear of ERR_CNT.

## Operation

**Step function.** S is the L-bit state. Generate W bits sequentially; each new bit is S[L-1] ^ S[T-1], where T = 6, 14, 18 or 28 by POLY. The bit shifts in at the LSB and the oldest bit drops out. The word equals the W generated bits, with the first-generated bit at the MSB. For W > L the recursion continues on the generated bits; the implementation uses an (L+W)-bit scratch vector.

**Generator (MODE=0)**

- Reset: S = all ones (low L bits), DOUT = 0, DOUT_VALID = 0.
- LOAD=1: S <= SEED[L-1:0]. If that value is zero, S <= all ones. No output is produced that cycle. LOAD has priority over GEN_EN.
- GEN_EN=1: S <= step(S), DOUT <= word, DOUT_VALID <= 1 on the next edge. Otherwise DOUT_VALID <= 0 and DOUT holds its value.

**Checker (MODE=1)**

FSM states: HUNT, SYNC, LOCK. Reset state is HUNT with S = 0, fill = 0, run = 0.

Each DIN_VALID word is compared against the predicted word step(S). A mismatch is any differing bit; popcount(pred ^ DIN) gives the error count.

- **HUNT / SYNC:**
  - S is reloaded from received data: the W bits of DIN are shifted into S, MSB first (self-synchronising).
  - fill counts received bits, saturating at L.
  - A word counts as a match only if fill = L before the word, pred == DIN, and S != 0.
  - HUNT goes to SYNC on the first match (run = 1).
  - In SYNC, each match increments run; a mismatch returns to HUNT with run = 0.
  - When run reaches LOCK_WORDS the FSM goes to LOCK. With LOCK_WORDS = 1, HUNT goes directly to LOCK.
- **LOCK:**
  - S <= step(S), free-running from its own prediction, so errors do not propagate.
  - Mismatch: ERR_FLAG pulses, ERR_CNT += popcount (saturating at all ones), and the bad-run counter increments. When it reaches LOSS_WORDS the FSM goes to HUNT, with fill = 0.
  - An error-free word clears the bad-run counter.
- ERR_CNT does not count in HUNT or SYNC.
- If ERR_CLR and an increment occur in the same cycle, the clear wins and the count becomes 0.
- A MODE change resets the FSM to HUNT, clears fill, run and the bad-run counter, and reloads S per the mode reset rule. ERR_CNT is kept.
- In generator mode, LOCKED = 0 and ERR_FLAG = 0. In checker mode, DOUT_VALID = 0.

## Timing

- All outputs are registered.
- Generator latency: GEN_EN at edge n gives DOUT/DOUT_VALID valid after edge n. Back-to-back GEN_EN gives one word per clock.
- Checker latency: a DIN_VALID word sampled at edge n updates LOCKED, ERR_FLAG and ERR_CNT after edge n.
- LOCKED rises after the edge that samples the LOCK_WORDS-th match. It falls after the edge that samples the LOSS_WORDS-th consecutive bad word.
- DIN_VALID=0 cycles change nothing: no counting and no state advance.
- Reset asserted mid-stream: all outputs return to their reset values immediately (asynchronously). ERR_CNT = 0.

## Test plan

- **Generator, PRBS23:** W=12, POLY=23, reset, GEN_EN held high -> DOUT sequence 0x000, 0x03E, ...; DOUT_VALID high one cycle after GEN_EN. Also compare against a bit-serial reference model over 10^5 words for each POLY and for W in {1, 12, 32, 64}.
- **Zero seed:** LOAD with SEED=0 -> output identical to the reset sequence (0x000, 0x03E). LOAD+GEN_EN in the same cycle -> no word emitted.
- **Checker acquisition:** DOUT looped to DIN, W=12, POLY=23, LOCK_WORDS=8 -> LOCKED rises after word ceil(23/12)+8 = 10. ERR_CNT stays 0. An all-zero DIN stream never locks.
- **Error injection:** while locked, flip 1 bit in one word, then 3 bits in another -> two ERR_FLAG pulses, ERR_CNT = 4, LOCKED stays 1, no error propagation into the following words.
- **Loss of lock:** 4 consecutive corrupted words (LOSS_WORDS=4) -> LOCKED drops after the 4th; 3 corrupted words then a clean one -> LOCKED stays. After the drop, clean data relocks in 10 words.
- **Saturation and clear:** CNT_W=4, inject 20 bit errors -> ERR_CNT = 15. ERR_CLR coincident with an error -> 0. RST_N pulsed mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// PRBS generator / self-synchronising checker, W bits per clock, PRBS7/15/23/31.
// Generator and checker keep separate LFSR states; the idle side is held at its reset value.
module prbs_gen_chk #(
  parameter int W          = 12,
  parameter int POLY       = 23,
  parameter int LOCK_WORDS = 8,
  parameter int LOSS_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MODE,
  input  logic [30:0]      SEED,
  input  logic             LOAD,
  input  logic             GEN_EN,
  output logic [W-1:0]     DOUT,
  output logic             DOUT_VALID,
  input  logic [W-1:0]     DIN,
  input  logic             DIN_VALID,
  output logic             LOCKED,
  output logic             ERR_FLAG,
  output logic [CNT_W-1:0] ERR_CNT,
  input  logic             ERR_CLR
);

  localparam int L  = POLY;
  localparam int T  = (POLY == 7) ? 6 : (POLY == 15) ? 14 : (POLY == 23) ? 18 : 28;
  localparam int FW = $clog2(L + W + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} chkState_t;

  // Upper L bits hold the current state; each lower bit is the tap XOR of bits L and T above it.
  function automatic logic [L+W-1:0] stepVec(input logic [L-1:0] s);
    logic [L+W-1:0] v;
    v = {s, {W{1'b0}}};
    for (int i = W - 1; i >= 0; i--) v[i] = v[i+L] ^ v[i+T];
    return v;
  endfunction

  function automatic logic [6:0] popCount(input logic [W-1:0] x);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + {6'b0, x[i]};
    return c;
  endfunction

  // ---------------- generator ----------------
  logic [L-1:0]   genState;
  logic [L+W-1:0] genVec;
  logic [L-1:0]   seedBits;

  assign genVec   = stepVec(genState);
  assign seedBits = SEED[L-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      genState   <= '1;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
    end else begin
      DOUT_VALID <= 1'b0;
      if (MODE) begin
        genState <= '1;
      end else if (LOAD) begin
        genState <= (seedBits == '0) ? '1 : seedBits;
      end else if (GEN_EN) begin
        genState   <= genVec[L-1:0];
        DOUT       <= genVec[W-1:0];
        DOUT_VALID <= 1'b1;
      end
    end
  end

  // ---------------- checker ----------------
  chkState_t      stateReg, stateNext;
  logic [L-1:0]   chkSReg, chkSNext;
  logic [FW-1:0]  fillReg, fillNext, fillSum;
  logic [7:0]     runReg, runNext, badReg, badNext;
  logic           errHit;
  logic [L+W-1:0] predVec, shiftCat;
  logic           mismatch, matchOk;
  logic [CNT_W+7:0] cntSum;
  logic           unusedBits;

  assign predVec  = stepVec(chkSReg);
  assign shiftCat = {chkSReg, DIN};
  assign mismatch = |(predVec[W-1:0] ^ DIN);
  assign fillSum  = fillReg + FW'(W);
  assign matchOk  = (fillReg == FW'(L)) && !mismatch && (chkSReg != '0);
  assign cntSum   = {8'b0, ERR_CNT} + {{(CNT_W+1){1'b0}}, popCount(predVec[W-1:0] ^ DIN)};
  assign unusedBits = ^{SEED, shiftCat, predVec, genVec};

  always_comb begin
    stateNext = stateReg;
    chkSNext  = chkSReg;
    fillNext  = fillReg;
    runNext   = runReg;
    badNext   = badReg;
    errHit    = 1'b0;
    if (!MODE) begin
      stateNext = HUNT;
      chkSNext  = '0;
      fillNext  = '0;
      runNext   = '0;
      badNext   = '0;
    end else if (DIN_VALID) begin
      case (stateReg)
        HUNT, SYNC: begin
          // Self-synchronise: the received bits themselves become the predictor state.
          chkSNext = shiftCat[L-1:0];
          fillNext = (fillSum > FW'(L)) ? FW'(L) : fillSum;
          if (matchOk) begin
            if (runReg + 8'd1 >= 8'(LOCK_WORDS)) begin
              stateNext = LOCK;
              runNext   = '0;
              badNext   = '0;
            end else begin
              stateNext = SYNC;
              runNext   = runReg + 8'd1;
            end
          end else begin
            stateNext = HUNT;
            runNext   = '0;
          end
        end
        default: begin
          chkSNext = predVec[L-1:0];
          if (mismatch) begin
            errHit = 1'b1;
            if (badReg + 8'd1 >= 8'(LOSS_WORDS)) begin
              stateNext = HUNT;
              fillNext  = '0;
              runNext   = '0;
              badNext   = '0;
            end else begin
              badNext = badReg + 8'd1;
            end
          end else begin
            badNext = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateReg <= HUNT;
      chkSReg  <= '0;
      fillReg  <= '0;
      runReg   <= '0;
      badReg   <= '0;
      LOCKED   <= 1'b0;
      ERR_FLAG <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      stateReg <= stateNext;
      chkSReg  <= chkSNext;
      fillReg  <= fillNext;
      runReg   <= runNext;
      badReg   <= badNext;
      LOCKED   <= (stateNext == LOCK);
      ERR_FLAG <= errHit;
      if (ERR_CLR)
        ERR_CNT <= '0;
      else if (errHit)
        ERR_CNT <= (|cntSum[CNT_W+7:CNT_W]) ? '1 : cntSum[CNT_W-1:0];
    end
  end

endmodule
